// File: rtl/wb4_fifo_drain_packer_if.sv
// Wishbone B4 pipelined read bus: one master issues cyc/stb, the slave
// answers with ack/data and can hold off strobes with stall.
`timescale 1ns/1ps
interface wb4_fifo_drain_packer_if #(
  parameter int unsigned P_DW = 8
) ();
  logic            cyc;
  logic            stb;
  logic            ack;
  logic            stall;
  logic [P_DW-1:0] data;

  modport master (output cyc, stb, input  ack, stall, data);
  modport slave  (input  cyc, stb, output ack, stall, data);
endinterface

// File: rtl/wb4_fifo_drain_packer.sv
// Drains narrow units from a WB4 pipelined FIFO read slave, packs P_RATIO
// consecutive units (first unit in the LSBs) and serves each packed word to a
// downstream WB4 pipelined master.
`timescale 1ns/1ps
module wb4_fifo_drain_packer #(
  parameter int unsigned P_DATA_MSB = 7,
  parameter int unsigned P_RATIO    = 4
) (
  input  logic                    i_wb4_sclk,
  input  logic                    i_wb4_srst,
  wb4_fifo_drain_packer_if.master wb4_in,
  wb4_fifo_drain_packer_if.slave  wb4_out
);
  localparam int unsigned UW = P_DATA_MSB + 1;
  localparam int unsigned WW = P_RATIO * UW;
  localparam int unsigned LW = $clog2(P_RATIO);
  localparam int unsigned CW = LW + 1;
  localparam logic [CW-1:0] FULL = CW'(P_RATIO);

  logic          run_q;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] filled_q, filled_d;
  logic [WW-1:0] pack_q, pack_d;
  logic [WW-1:0] word_q, word_d;
  logic          wv_q, wv_d;
  logic          sack_q, sack_d;
  logic [WW-1:0] sdata_q, sdata_d;

  logic [CW:0]   used;
  logic          mstb;
  logic          accept;
  logic          capture;
  logic          rd;
  logic          xfer;

  // Strobe/cycle come from registered state only; run_q holds them low
  // during reset and releases them one cycle after reset is removed.
  always_comb begin
    used    = {1'b0, filled_q} + {1'b0, outst_q};
    mstb    = run_q && (used < {1'b0, FULL}) && (filled_q != FULL);
    accept  = mstb && !wb4_in.stall;
    capture = wb4_in.ack && (outst_q != '0);
    rd      = wb4_out.cyc && wb4_out.stb && wv_q;
    xfer    = (filled_q == FULL) && (!wv_q || rd);
  end

  assign wb4_in.cyc    = mstb || (outst_q != '0);
  assign wb4_in.stb    = mstb;
  assign wb4_out.ack   = sack_q;
  assign wb4_out.data  = sdata_q;
  assign wb4_out.stall = !wv_q;

  // Next-state for counters, lane packing, the buffered word and the read port.
  // The served data gets its own register so a transfer reloading the buffer
  // in the same cycle as a read cannot overwrite the word being acked.
  always_comb begin
    outst_d  = outst_q;
    filled_d = filled_q;
    pack_d   = pack_q;
    word_d   = word_q;
    wv_d     = wv_q;
    sack_d   = rd;
    sdata_d  = sdata_q;

    if (accept && !capture) begin
      outst_d = outst_q + CW'(1);
    end else if (!accept && capture) begin
      outst_d = outst_q - CW'(1);
    end

    if (capture) begin
      pack_d[filled_q[LW-1:0]*UW +: UW] = wb4_in.data;
    end

    if (xfer) begin
      filled_d = '0;
      word_d   = pack_q;
      wv_d     = 1'b1;
    end else begin
      if (capture) begin
        filled_d = filled_q + CW'(1);
      end
      if (rd) begin
        wv_d = 1'b0;
      end
    end

    if (rd) begin
      sdata_d = word_q;
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge i_wb4_sclk) begin
    if (i_wb4_srst) begin
      run_q    <= 1'b0;
      outst_q  <= '0;
      filled_q <= '0;
      pack_q   <= '0;
      word_q   <= '0;
      wv_q     <= 1'b0;
      sack_q   <= 1'b0;
      sdata_q  <= '0;
    end else begin
      run_q    <= 1'b1;
      outst_q  <= outst_d;
      filled_q <= filled_d;
      pack_q   <= pack_d;
      word_q   <= word_d;
      wv_q     <= wv_d;
      sack_q   <= sack_d;
      sdata_q  <= sdata_d;
    end
  end
endmodule

// File: tb/tb_wb4_fifo_drain_packer.sv
// Bench for wb4_fifo_drain_packer: behavioural FIFO read slave upstream,
// directed downstream reads, and a scoreboard of expected packed words.
`timescale 1ns/1ps
module tb_wb4_fifo_drain_packer;
  localparam int unsigned UW = 8;
  localparam int unsigned WW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb4_fifo_drain_packer_if #(.P_DW(UW)) in_if ();
  wb4_fifo_drain_packer_if #(.P_DW(WW)) out_if ();

  wb4_fifo_drain_packer #(.P_DATA_MSB(7), .P_RATIO(4)) dut (
    .i_wb4_sclk (clk),
    .i_wb4_srst (rst),
    .wb4_in     (in_if),
    .wb4_out    (out_if)
  );

  int errors = 0;
  int checks = 0;

  // FIFO model state
  logic [UW-1:0] fifo_q[$];
  int            avail     = 0;
  int            acc_cnt   = 0;
  int            ack_total = 0;
  int            gap_at    = 0;
  int            gap_len   = 0;
  int            stall_cnt = 0;
  logic          f_ack     = 1'b0;
  logic          f_stall   = 1'b1;
  logic [UW-1:0] f_data    = '0;
  logic          spur_ack  = 1'b0;
  logic [UW-1:0] spur_data = '0;

  assign in_if.ack   = f_ack | spur_ack;
  assign in_if.data  = spur_ack ? spur_data : f_data;
  assign in_if.stall = f_stall;

  logic [WW-1:0] exp_q[$];

  // FIFO read slave: one-cycle ack per accepted strobe, stalls when empty
  // or during a programmed gap after the gap_at-th accepted strobe.
  initial begin
    logic s;
    forever begin
      @(negedge clk);
      s = (in_if.stb === 1'b1) && !f_stall && !rst;
      @(posedge clk);
      #1;
      if (s) begin
        avail--;
        acc_cnt++;
      end
      if (s && fifo_q.size() > 0) begin
        f_ack  = 1'b1;
        f_data = fifo_q.pop_front();
        ack_total++;
      end else begin
        f_ack = 1'b0;
      end
      if (stall_cnt > 0) stall_cnt--;
      if (s && acc_cnt == gap_at) stall_cnt = gap_len;
      f_stall = (avail <= 0) || (stall_cnt > 0);
    end
  end

  // Monitor: every downstream ack must match the next expected word.
  initial begin
    logic [WW-1:0] e;
    forever begin
      @(negedge clk);
      if (out_if.ack === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_ack: got=%h required=no ack", out_if.data);
        end else begin
          e = exp_q.pop_front();
          if (out_if.data !== e) begin
            errors++;
            $display("FAIL packed_word: got=%h required=%h", out_if.data, e);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got=%h required=%h", name, act, req);
    end
  endtask

  task automatic load(input logic [UW-1:0] v);
    fifo_q.push_back(v);
    avail++;
  endtask

  // Waits (bounded) for a word, then issues a single-cycle read strobe.
  task automatic read_word();
    int ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (out_if.stall === 1'b0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (ok == 0) begin
      checks++;
      errors++;
      $display("FAIL read_timeout: got=stall required=word available");
    end else begin
      out_if.cyc = 1'b1;
      out_if.stb = 1'b1;
      @(negedge clk);
      out_if.cyc = 1'b0;
      out_if.stb = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int gap_seen;
    out_if.cyc = 1'b0;
    out_if.stb = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_mcyc", in_if.cyc, 0);
    chk("rst_mstb", in_if.stb, 0);
    chk("rst_sack", out_if.ack, 0);
    chk("rst_sdata", out_if.data, 0);
    chk("rst_sstall", out_if.stall, 1);

    // Basic pack and first-word latency
    load(8'h11); load(8'h22); load(8'h33); load(8'h44);
    exp_q.push_back(32'h44332211);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (out_if.stall === 1'b0) begin
        lat = i;
        break;
      end
    end
    chk("word_latency", lat, 7);
    chk("mstb_fifo_empty", in_if.stb, 1);
    chk("mcyc_fifo_empty", in_if.cyc, 1);
    read_word();
    repeat (2) @(negedge clk);
    chk("sstall_after_read", out_if.stall, 1);

    // Three-cycle FIFO stall between units 2 and 3
    acc_cnt = 0;
    gap_at  = 2;
    gap_len = 3;
    gap_seen = 0;
    load(8'h55); load(8'h66); load(8'h77); load(8'h88);
    exp_q.push_back(32'h88776655);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (stall_cnt > 0) begin
        gap_seen++;
        chk("mstb_held_in_stall", in_if.stb, 1);
      end
    end
    chk("stall_gap_cycles", gap_seen, 3);
    gap_at = 0;
    read_word();

    // Downstream idle: one word buffered, one packed, then upstream stops
    base = ack_total;
    for (int i = 1; i <= 12; i++) load(UW'(i));
    exp_q.push_back(32'h04030201);
    exp_q.push_back(32'h08070605);
    exp_q.push_back(32'h0C0B0A09);
    repeat (40) @(negedge clk);
    chk("blocked_ack_count", ack_total - base, 8);
    chk("blocked_mstb", in_if.stb, 0);
    chk("blocked_mcyc", in_if.cyc, 0);
    chk("blocked_sstall", out_if.stall, 0);

    // Spurious ack while idle must be ignored
    spur_data = 8'hEE;
    spur_ack  = 1'b1;
    @(negedge clk);
    spur_ack  = 1'b0;
    repeat (2) @(negedge clk);
    chk("spur_sstall", out_if.stall, 0);
    chk("spur_mcyc", in_if.cyc, 0);
    read_word();
    read_word();
    repeat (20) @(negedge clk);
    read_word();
    chk("blocked_total_acks", ack_total - base, 12);

    // Reset mid-burst with one word buffered and a partial pack in flight
    base = ack_total;
    for (int i = 0; i < 7; i++) load(UW'(8'h21 + i));
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ack_total - base >= 7) begin
        lat = 1;
        break;
      end
    end
    chk("midburst_reached", lat, 1);
    chk("pre_reset_sstall", out_if.stall, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mcyc", in_if.cyc, 0);
    chk("midrst_mstb", in_if.stb, 0);
    chk("midrst_sack", out_if.ack, 0);
    chk("midrst_sdata", out_if.data, 0);
    chk("midrst_sstall", out_if.stall, 1);
    fifo_q.delete();
    avail   = 0;
    acc_cnt = 0;
    repeat (2) @(negedge clk);
    load(8'h31); load(8'h32); load(8'h33); load(8'h34);
    exp_q.push_back(32'h34333231);
    rst = 1'b0;
    @(negedge clk);
    spur_data = 8'hEE;
    spur_ack  = 1'b1;
    @(negedge clk);
    spur_ack  = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (out_if.stall === 1'b0) break;
      @(negedge clk);
    end

    // scyc low with sstb high: no ack, word retained
    out_if.cyc = 1'b0;
    out_if.stb = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("nocyc_sack", out_if.ack, 0);
      chk("nocyc_sstall", out_if.stall, 0);
    end
    out_if.stb = 1'b0;
    read_word();

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
